// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for mem_arbiter: FSM states, data_type size codes, I/O region decode.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IFETCH = 3'd1,
    ST_DLOAD  = 3'd2,
    ST_DSTORE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int         DT_UNSIGNED_BIT = 2;
  localparam logic [1:0] IO_REGION = 2'b11;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// load_extend: widens assembled load lanes to 32 bits with sign or zero fill by size.
module load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] i_lanes,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_res
);

  always_comb begin
    o_res = i_lanes;
    case (i_size)
      SZ_BYTE: o_res = {{24{~i_unsigned & i_lanes[7]}}, i_lanes[7:0]};
      SZ_HALF: o_res = {{16{~i_unsigned & i_lanes[15]}}, i_lanes[15:0]};
      default: o_res = i_lanes;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and load/store requests onto the byte-wide memory bus.
// Define MEM_ARB_IO_STALL_EN to hold stores into the I/O region while the UART TX buffer is full.
// state  | meaning
// IDLE   | waiting for a request (data has priority)
// IFETCH | word fetch, one byte per cycle, lanes captured a cycle late
// DLOAD  | data load, same byte sequencing as IFETCH
// DSTORE | one write byte per cycle; never aborted by clear
// DONE   | one-cycle ready pulse to the requester
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rdy,
  input  logic              i_clear,
  input  logic              i_inst_valid,
  input  logic [ADDR_W-1:0] i_inst_addr,
  output logic              o_inst_ready,
  output logic [31:0]       o_inst_res,
  input  logic              i_data_valid,
  input  logic              i_data_wr,
  input  logic [2:0]        i_data_type,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [31:0]       i_data_value,
  output logic              o_data_ready,
  output logic [31:0]       o_data_res,
  input  logic [7:0]        i_mem_din,
  output logic [7:0]        o_mem_dout,
  output logic [31:0]       o_mem_a,
  output logic              o_mem_wr,
  input  logic              i_io_buffer_full
);

  state_e            r_state, w_state_next;
  logic [2:0]        r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_size;
  logic              r_unsigned, r_is_inst, r_is_wr;
  logic [31:0]       r_wdata, r_lanes, r_inst_res, r_data_res;
  logic [2:0]        w_nbytes;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_bus_addr, w_lanes_next, w_ext;
  logic [1:0]        w_lane_idx;
  logic              w_io_stall, w_accept_data, w_accept_inst, w_capture, w_finish;

  assign w_nbytes   = size_bytes(r_size);
  assign w_addr     = r_base + ADDR_W'(r_cnt);
  assign w_bus_addr = 32'(w_addr);
  assign w_lane_idx = 2'(r_cnt - 3'd1);

`ifdef MEM_ARB_IO_STALL_EN
  assign w_io_stall = (w_bus_addr[17:16] == IO_REGION) && i_io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = i_io_buffer_full;
  assign w_io_stall  = 1'b0;
`endif

  // The byte on i_mem_din answers the address driven one cycle earlier.
  always_comb begin
    w_lanes_next = r_lanes;
    w_lanes_next[8*w_lane_idx +: 8] = i_mem_din;
  end

  load_extend u_load_extend (
    .i_lanes   (w_lanes_next),
    .i_size    (r_size),
    .i_unsigned(r_unsigned),
    .o_res     (w_ext)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_accept_data = 1'b0;
    w_accept_inst = 1'b0;
    w_capture     = 1'b0;
    w_finish      = 1'b0;
    o_mem_a       = '0;
    o_mem_dout    = '0;
    o_mem_wr      = 1'b0;
    o_inst_ready  = 1'b0;
    o_data_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_rdy && !i_clear) begin
          if (i_data_valid) begin
            w_accept_data = 1'b1;
            w_cnt_next    = '0;
            w_state_next  = i_data_wr ? ST_DSTORE : ST_DLOAD;
          end else if (i_inst_valid) begin
            w_accept_inst = 1'b1;
            w_cnt_next    = '0;
            w_state_next  = ST_IFETCH;
          end
        end
      end
      ST_IFETCH, ST_DLOAD: begin
        if (r_cnt < w_nbytes) o_mem_a = w_bus_addr;
        if (i_rdy) begin
          if (i_clear) begin
            w_state_next = ST_IDLE;
          end else begin
            w_capture = (r_cnt != 3'd0);
            if (r_cnt == w_nbytes) begin
              w_finish     = 1'b1;
              w_state_next = ST_DONE;
            end else begin
              w_cnt_next = r_cnt + 3'd1;
            end
          end
        end
      end
      ST_DSTORE: begin
        o_mem_a    = w_bus_addr;
        o_mem_dout = r_wdata[8*r_cnt[1:0] +: 8];
        if (i_rdy && !w_io_stall) begin
          o_mem_wr = 1'b1;
          if (r_cnt == w_nbytes - 3'd1) w_state_next = ST_DONE;
          else                          w_cnt_next   = r_cnt + 3'd1;
        end
      end
      ST_DONE: begin
        if (i_rdy) begin
          w_state_next = ST_IDLE;
          o_inst_ready = r_is_inst && !i_clear;
          o_data_ready = !r_is_inst && (r_is_wr || !i_clear);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base     <= '0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_is_inst  <= 1'b0;
      r_is_wr    <= 1'b0;
      r_wdata    <= '0;
      r_lanes    <= '0;
      r_inst_res <= '0;
      r_data_res <= '0;
    end else begin
      if (w_accept_data) begin
        r_base     <= i_data_addr;
        r_size     <= i_data_type[1:0];
        r_unsigned <= i_data_type[DT_UNSIGNED_BIT];
        r_is_inst  <= 1'b0;
        r_is_wr    <= i_data_wr;
        r_wdata    <= i_data_value;
      end else if (w_accept_inst) begin
        r_base     <= i_inst_addr;
        r_size     <= SZ_WORD;
        r_unsigned <= 1'b1;
        r_is_inst  <= 1'b1;
        r_is_wr    <= 1'b0;
      end
      if (w_capture) r_lanes <= w_lanes_next;
      if (w_finish) begin
        if (r_is_inst) r_inst_res <= w_lanes_next;
        else           r_data_res <= w_ext;
      end
    end
  end

  assign o_inst_res = r_inst_res;
  assign o_data_res = r_data_res;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus cycles and ready pulses are queued, a monitor compares.
module tb_mem_arbiter;

  logic        clk, rst_n, rdy, clear;
  logic        inst_valid, inst_ready, data_valid, data_wr, data_ready;
  logic [31:0] inst_addr, inst_res, data_addr, data_value, data_res, mem_a;
  logic [2:0]  data_type;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_wr, io_full;

  mem_arbiter #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rdy(rdy), .i_clear(clear),
    .i_inst_valid(inst_valid), .i_inst_addr(inst_addr),
    .o_inst_ready(inst_ready), .o_inst_res(inst_res),
    .i_data_valid(data_valid), .i_data_wr(data_wr), .i_data_type(data_type),
    .i_data_addr(data_addr), .i_data_value(data_value),
    .o_data_ready(data_ready), .o_data_res(data_res),
    .i_mem_din(mem_din), .o_mem_dout(mem_dout), .o_mem_a(mem_a), .o_mem_wr(mem_wr),
    .i_io_buffer_full(io_full)
  );

  typedef struct {logic [31:0] a; logic wr; logic [7:0] d;} bus_t;
  typedef struct {bit is_inst; logic [31:0] res; int cyc; bit chk;} rsp_t;
  typedef struct {logic [31:0] a; logic [2:0] t; logic [31:0] e;} ld_t;

  bus_t bq[$];
  rsp_t rq[$];
  bus_t mb;
  rsp_t mr;
  ld_t  lds[5];
  int   tests = 0, fails = 0, cyc = 0, acc = 0, seen = 0;
  logic [7:0]  mem [int unsigned];
  logic [31:0] last_a = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Byte-wide memory model: one-cycle read latency, writes land at the strobe.
  always @(negedge clk) begin
    last_a = mem_a;
    if (rst_n && mem_wr) mem[mem_a] = mem_dout;
  end
  always @(posedge clk) begin
    #1;
    mem_din = mem.exists(last_a) ? mem[last_a] : 8'h00;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_a != 32'h0) begin
        tests++;
        if (bq.size() == 0) begin
          fails++;
          $display("FAIL bus_unexpected @%0d: got a=%h wr=%b d=%h, expected no bus cycle", cyc, mem_a, mem_wr, mem_dout);
        end else begin
          mb = bq.pop_front();
          if (mem_a !== mb.a || mem_wr !== mb.wr || (mb.wr && mem_dout !== mb.d)) begin
            fails++;
            $display("FAIL bus_cycle @%0d: got a=%h wr=%b d=%h, expected a=%h wr=%b d=%h",
                     cyc, mem_a, mem_wr, mem_dout, mb.a, mb.wr, mb.d);
          end
        end
      end else if (mem_wr) begin
        tests++;
        fails++;
        $display("FAIL bus_idle_wr @%0d: got wr=1 with a=0, expected wr=0", cyc);
      end
      if (inst_ready || data_ready) begin
        tests++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL ready_unexpected @%0d: got inst_ready=%b data_ready=%b, expected none", cyc, inst_ready, data_ready);
        end else begin
          mr = rq.pop_front();
          if (inst_ready !== mr.is_inst || data_ready !== !mr.is_inst || cyc != mr.cyc ||
              (mr.chk && (mr.is_inst ? inst_res : data_res) !== mr.res)) begin
            fails++;
            $display("FAIL ready_rsp: got inst_ready=%b data_ready=%b cyc=%0d inst_res=%h data_res=%h, expected inst=%b cyc=%0d res=%h",
                     inst_ready, data_ready, cyc, inst_res, data_res, mr.is_inst, mr.cyc, mr.res);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic push_rd(input logic [31:0] a);
    bq.push_back('{a, 1'b0, 8'h00});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    bq.push_back('{a, 1'b1, d});
  endtask

  task automatic push_rsp(input bit is_inst, input logic [31:0] res, input int c, input bit chk_res);
    rq.push_back('{is_inst, res, c, chk_res});
  endtask

  task automatic wait_ready(input bit is_inst);
    int  n = 0;
    bit  got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      got = is_inst ? inst_ready : data_ready;
      n++;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL ready_timeout: got no %s ready in 40 cycles, expected a pulse", is_inst ? "inst" : "data");
    end
    @(posedge clk); #1;
    if (is_inst) inst_valid = 1'b0;
    else         data_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    inst_valid = 1'b1; inst_addr = a; acc = cyc;
    for (int k = 0; k < 4; k++) push_rd(a + k);
    push_rsp(1'b1, exp, acc + 6, 1'b1);
    wait_ready(1'b1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] exp);
    int n = nb(t[1:0]);
    @(posedge clk); #1;
    data_valid = 1'b1; data_wr = 1'b0; data_type = t; data_addr = a; acc = cyc;
    for (int k = 0; k < n; k++) push_rd(a + k);
    push_rsp(1'b0, exp, acc + n + 2, 1'b1);
    wait_ready(1'b0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] v);
    int n = nb(t[1:0]);
    logic [31:0] vv = v;
    @(posedge clk); #1;
    data_valid = 1'b1; data_wr = 1'b1; data_type = t; data_addr = a; data_value = v; acc = cyc;
    for (int k = 0; k < n; k++) push_wr(a + k, vv[8*k +: 8]);
    push_rsp(1'b0, 32'h0, acc + n + 1, 1'b0);
    wait_ready(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; io_full = 1'b0; mem_din = 8'h00;
    inst_valid = 1'b0; inst_addr = '0; data_valid = 1'b0; data_wr = 1'b0;
    data_type = 3'b000; data_addr = '0; data_value = '0;
    mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h05; mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h00;
    mem[32'h2000] = 8'h80; mem[32'h2001] = 8'h11; mem[32'h2002] = 8'hFF; mem[32'h2003] = 8'h80;
    lds[0] = '{32'h2002, 3'b101, 32'h000080FF};
    lds[1] = '{32'h2002, 3'b001, 32'hFFFF80FF};
    lds[2] = '{32'h2000, 3'b100, 32'h00000080};
    lds[3] = '{32'h1000, 3'b010, 32'h00000513};
    lds[4] = '{32'h1001, 3'b000, 32'h00000005};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst_inst_ready", {31'h0, inst_ready}, 32'h0);
    chk("rst_data_ready", {31'h0, data_ready}, 32'h0);
    chk("rst_inst_res", inst_res, 32'h0);
    chk("rst_data_res", data_res, 32'h0);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_fetch(32'h1000, 32'h00000513);

    // Both requesters at once: data first, fetch accepted in the IDLE cycle after DONE.
    @(posedge clk); #1;
    inst_valid = 1'b1; inst_addr = 32'h1000;
    data_valid = 1'b1; data_wr = 1'b0; data_type = 3'b000; data_addr = 32'h2000; acc = cyc;
    push_rd(32'h2000);
    for (int k = 0; k < 4; k++) push_rd(32'h1000 + k);
    push_rsp(1'b0, 32'hFFFFFF80, acc + 3, 1'b1);
    push_rsp(1'b1, 32'h00000513, acc + 10, 1'b1);
    wait_ready(1'b0);
    wait_ready(1'b1);

    for (int i = 0; i < 5; i++) do_load(lds[i].a, lds[i].t, lds[i].e);

    do_store(32'h3000, 3'b010, 32'hDEADBEEF);
    do_load(32'h3000, 3'b010, 32'hDEADBEEF);

    // clear during the second fetch byte aborts silently
    @(posedge clk); #1;
    inst_valid = 1'b1; inst_addr = 32'h1000; acc = cyc;
    push_rd(32'h1000); push_rd(32'h1001);
    repeat (2) begin @(posedge clk); #1; end
    clear = 1'b1; inst_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("idle_after_clear", mem_a, 32'h0);
    seen = 0;
    repeat (8) begin @(negedge clk); if (inst_ready) seen++; end
    chk("no_ready_after_clear", seen, 0);

    // clear during a store does not abort it
    @(posedge clk); #1;
    data_valid = 1'b1; data_wr = 1'b1; data_type = 3'b001; data_addr = 32'h3010; data_value = 32'h0000A55A; acc = cyc;
    push_wr(32'h3010, 8'h5A); push_wr(32'h3011, 8'hA5);
    push_rsp(1'b0, 32'h0, acc + 3, 1'b0);
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    wait_ready(1'b0);
    do_load(32'h3010, 3'b001, 32'hFFFFA55A);

    // rdy low for one cycle repeats byte 0 and delays the pulse by one
    @(posedge clk); #1;
    data_valid = 1'b1; data_wr = 1'b0; data_type = 3'b000; data_addr = 32'h2000; acc = cyc;
    push_rd(32'h2000); push_rd(32'h2000);
    push_rsp(1'b0, 32'hFFFFFF80, acc + 4, 1'b1);
    @(posedge clk); #1; rdy = 1'b0;
    @(posedge clk); #1; rdy = 1'b1;
    wait_ready(1'b0);

    @(posedge clk); #1;
    data_valid = 1'b1; data_wr = 1'b1; data_type = 3'b000; data_addr = 32'h30000; data_value = 32'h00000077;
    io_full = 1'b1; acc = cyc;
`ifdef MEM_ARB_IO_STALL_EN
    for (int k = 0; k < 3; k++) push_rd(32'h30000);
    push_wr(32'h30000, 8'h77);
    push_rsp(1'b0, 32'h0, acc + 5, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    io_full = 1'b0;
    wait_ready(1'b0);
`else
    push_wr(32'h30000, 8'h77);
    push_rsp(1'b0, 32'h0, acc + 2, 1'b0);
    wait_ready(1'b0);
    io_full = 1'b0;
`endif

    // asynchronous reset in the middle of a fetch
    @(posedge clk); #1;
    inst_valid = 1'b1; inst_addr = 32'h1000;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_a", mem_a, 32'h0);
    chk("async_rst_inst_res", inst_res, 32'h0);
    chk("async_rst_data_res", data_res, 32'h0);
    inst_valid = 1'b0;
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bus_queue_drained", bq.size(), 0);
    chk("rsp_queue_drained", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
